// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: machine word, reset defaults and fetch states.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam word_t PC_INC_DEFAULT       = 32'd4;

  // REQ: request outstanding/issuing at PC; HOLD: word captured while ID stalled
  typedef enum logic [0:0] {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready
// handshake and presents them to the IF/ID register with branch, delay-slot
// and exception redirect handling.
//
// Ports:
//   CLK, RST_N                        clock, async active-low reset
//   IMEM_Req/Addr/Ready/RData         instruction memory handshake
//   ID_Stall                          back-pressure from ID
//   ID_IsBranch/BranchTaken/Target    branch resolved in ID (IF holds its delay slot)
//   ID_CancelBDS                      branch-likely not taken, squash delay slot
//   EXC_Redirect/EXC_Vector           exception or ERET redirect
//   IF_Instruction/PC/PCAdd4/IsBDS    presented instruction and its attributes
//   IF_Stall/IF_Flush                 no instruction / squash presented instruction
//
// Build option IF_ADDR_ERR_EN: adds IF_AddrErr and reports misaligned PCs
// instead of forcing PC[1:0] to zero.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter word_t PC_INC       = PC_INC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Ready,
  input  logic [31:0] IMEM_RData,
  input  logic        ID_Stall,
  input  logic        ID_IsBranch,
  input  logic        ID_BranchTaken,
  input  logic [31:0] ID_BranchTarget,
  input  logic        ID_CancelBDS,
  input  logic        EXC_Redirect,
  input  logic [31:0] EXC_Vector,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_IsBDS,
  output logic        IF_Stall,
  output logic        IF_Flush
`ifdef IF_ADDR_ERR_EN
  ,
  output logic        IF_AddrErr
`endif
);

  // Value written into the PC on any load
  function automatic word_t pc_load(input word_t a);
`ifdef IF_ADDR_ERR_EN
    return a;
`else
    return {a[XLEN-1:2], 2'b00};
`endif
  endfunction

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  word_t        redir_q, redir_d;
  logic         squash_q, squash_d;
  word_t        hold_q, hold_d;

  logic  in_req_c;
  logic  addr_err_c;
  logic  valid_c;
  logic  deliver_c;
  logic  br_take_c;
  word_t next_pc_c;

  assign in_req_c = (state_q == REQ);

`ifdef IF_ADDR_ERR_EN
  assign addr_err_c = RST_N & in_req_c & ~squash_q & (pc_q[1:0] != 2'b00);
  assign IF_AddrErr = addr_err_c;
`else
  assign addr_err_c = 1'b0;
`endif

  // A squashed response is never presented; an address error presents a dummy word
  assign valid_c   = RST_N & ((in_req_c & IMEM_Ready & ~squash_q) | ~in_req_c | addr_err_c);
  assign deliver_c = valid_c & ~ID_Stall & ~addr_err_c;
  assign br_take_c = ID_IsBranch & ID_BranchTaken & ~ID_Stall & ~EXC_Redirect;

  // Branch resolving in the delay-slot cycle bypasses the pending register
  assign next_pc_c = pc_load(br_take_c  ? ID_BranchTarget :
                             pend_vld_q ? pend_q          :
                                          pc_q + PC_INC);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= REQ;
      pc_q       <= pc_load(RESET_VECTOR);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      redir_q    <= '0;
      squash_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      redir_q    <= redir_d;
      squash_q   <= squash_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state: exception > squash drain > delivery > capture on stall
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    redir_d    = redir_q;
    squash_d   = squash_q;
    hold_d     = hold_q;

    if (EXC_Redirect) begin
      pend_vld_d = 1'b0;
      if (in_req_c && !IMEM_Ready && !addr_err_c) begin
        // Address must stay stable; remember the vector until the response drains
        squash_d = 1'b1;
        redir_d  = pc_load(EXC_Vector);
      end else begin
        pc_d     = pc_load(EXC_Vector);
        squash_d = 1'b0;
        state_d  = REQ;
      end
    end else begin
      if (in_req_c && IMEM_Ready && squash_q) begin
        pc_d     = redir_q;
        squash_d = 1'b0;
      end else if (deliver_c) begin
        pc_d       = next_pc_c;
        pend_vld_d = 1'b0;
        state_d    = REQ;
      end else if (in_req_c && IMEM_Ready && !addr_err_c && ID_Stall) begin
        hold_d  = IMEM_RData;
        state_d = HOLD;
      end
      if (br_take_c && !deliver_c) begin
        pend_d     = ID_BranchTarget;
        pend_vld_d = 1'b1;
      end
    end
  end

  // Pipeline-facing outputs; reset forces the quiet values
  always_comb begin
    IF_Instruction = '0;
    if (valid_c && !addr_err_c) begin
      IF_Instruction = in_req_c ? IMEM_RData : hold_q;
    end
  end

  assign IMEM_Req  = RST_N & in_req_c & ~addr_err_c;
  assign IMEM_Addr = pc_q;
  assign IF_PC     = pc_q;
  assign IF_PCAdd4 = pc_q + 32'd4;
  assign IF_IsBDS  = RST_N & ID_IsBranch;
  assign IF_Stall  = ~valid_c;
  assign IF_Flush  = RST_N & (EXC_Redirect | (ID_CancelBDS & ~ID_Stall));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then randomized traffic, checked
// by a program-flow reference model feeding a scoreboard of expected deliveries.
module tb_if_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ready;
  logic [31:0] IMEM_RData;
  logic        ID_Stall;
  logic        ID_IsBranch;
  logic        ID_BranchTaken;
  logic [31:0] ID_BranchTarget;
  logic        ID_CancelBDS;
  logic        EXC_Redirect;
  logic [31:0] EXC_Vector;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCAdd4;
  logic        IF_IsBDS;
  logic        IF_Stall;
  logic        IF_Flush;

  if_fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .IMEM_Req(IMEM_Req), .IMEM_Addr(IMEM_Addr), .IMEM_Ready(IMEM_Ready), .IMEM_RData(IMEM_RData),
    .ID_Stall(ID_Stall), .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
    .ID_BranchTarget(ID_BranchTarget), .ID_CancelBDS(ID_CancelBDS),
    .EXC_Redirect(EXC_Redirect), .EXC_Vector(EXC_Vector),
    .IF_Instruction(IF_Instruction), .IF_PC(IF_PC), .IF_PCAdd4(IF_PCAdd4),
    .IF_IsBDS(IF_IsBDS), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        bds;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Program-flow reference: PC of the next instruction the pipeline should receive
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_pend_vld;

  logic        req_pend_prev = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc       = RV;
    m_pend     = '0;
    m_pend_vld = 1'b0;
  endtask

  // One cycle of stimulus; pushes the expected delivery when one is due
  task automatic step(input logic rdy, input logic stall, input logic isbr, input logic taken,
                      input logic [31:0] tgt, input logic cancel, input logic exc,
                      input logic [31:0] vec);
    @(negedge CLK);
    IMEM_Ready      = rdy & IMEM_Req;
    IMEM_RData      = IMEM_Ready ? mem_word(IMEM_Addr) : $urandom;
    ID_Stall        = stall;
    ID_IsBranch     = isbr;
    ID_BranchTaken  = taken;
    ID_BranchTarget = tgt;
    ID_CancelBDS    = cancel;
    EXC_Redirect    = exc;
    EXC_Vector      = vec;
    #1;
    if (RST_N) begin
      if (exc) begin
        m_pc       = vec & 32'hFFFF_FFFC;
        m_pend_vld = 1'b0;
      end else if (!IF_Stall && !stall) begin
        sb.push_back('{pc: m_pc, ins: mem_word(m_pc), fl: cancel, bds: isbr});
        if (isbr && taken)   m_pc = tgt & 32'hFFFF_FFFC;
        else if (m_pend_vld) m_pc = m_pend & 32'hFFFF_FFFC;
        else                 m_pc = m_pc + 32'd4;
        m_pend_vld = 1'b0;
      end else if (isbr && taken && !stall) begin
        m_pend     = tgt;
        m_pend_vld = 1'b1;
      end
    end
  endtask

  // Monitor: compares every accepted delivery against the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (RST_N) begin
      if (req_pend_prev) begin
        chk("req_held", 32'(IMEM_Req), 32'd1);
        chk("addr_stable", IMEM_Addr, prev_addr);
      end
      if (EXC_Redirect) begin
        chk("exc_flush", 32'(IF_Flush), 32'd1);
      end else if (!IF_Stall && !ID_Stall) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: actual pc=%h required=none", IF_PC);
        end else begin
          e = sb.pop_front();
          chk("pc", IF_PC, e.pc);
          chk("pcadd4", IF_PCAdd4, e.pc + 32'd4);
          chk("instr", IF_Instruction, e.ins);
          chk("flush", 32'(IF_Flush), 32'(e.fl));
          chk("isbds", 32'(IF_IsBDS), 32'(e.bds));
        end
      end
      req_pend_prev = IMEM_Req & ~IMEM_Ready;
      prev_addr     = IMEM_Addr;
    end else begin
      req_pend_prev = 1'b0;
    end
  end

  initial begin
    logic [31:0] r;
    logic [31:0] t;
    logic [31:0] v;
    logic        isbr;
    logic        taken;

    RST_N = 1'b0;
    IMEM_Ready = 1'b0; IMEM_RData = '0; ID_Stall = 1'b0; ID_IsBranch = 1'b0;
    ID_BranchTaken = 1'b0; ID_BranchTarget = '0; ID_CancelBDS = 1'b0;
    EXC_Redirect = 1'b0; EXC_Vector = '0;
    model_reset();

    // Reset values with noisy inputs
    repeat (2) @(negedge CLK);
    IMEM_Ready = 1'b1; IMEM_RData = 32'hFFFF_FFFF; ID_IsBranch = 1'b1;
    EXC_Redirect = 1'b1; ID_CancelBDS = 1'b1;
    #1;
    chk("rst_req", 32'(IMEM_Req), 32'd0);
    chk("rst_stall", 32'(IF_Stall), 32'd1);
    chk("rst_flush", 32'(IF_Flush), 32'd0);
    chk("rst_instr", IF_Instruction, 32'd0);
    chk("rst_bds", 32'(IF_IsBDS), 32'd0);

    @(negedge CLK);
    IMEM_Ready = 1'b0; ID_IsBranch = 1'b0; EXC_Redirect = 1'b0; ID_CancelBDS = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("first_req", 32'(IMEM_Req), 32'd1);
    chk("first_addr", IMEM_Addr, RV);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("seq_addr", IMEM_Addr, RV + 32'(i * 4));
      chk("seq_stall", 32'(IF_Stall), 32'd0);
    end

    // Taken branch; 0xBFC00010 is its delay slot
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 1'b0, '0);
    chk("bds_addr", IMEM_Addr, 32'hBFC0_0010);

    // ID stall for 3 cycles with memory ready
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("tgt_addr", IMEM_Addr, 32'h8000_1000);
    chk("stall_req0", 32'(IMEM_Req), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("hold_noreq", 32'(IMEM_Req), 32'd0);
      chk("hold_stall", 32'(IF_Stall), 32'd0);
      chk("hold_instr", IF_Instruction, mem_word(32'h8000_1000));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("hold_release_noreq", 32'(IMEM_Req), 32'd0);

    // Delayed response with an exception in the second cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("exc_addr1", IMEM_Addr, 32'h8000_1004);
    chk("exc_flush1", 32'(IF_Flush), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h8000_0180);
    chk("exc_addr2", IMEM_Addr, 32'h8000_1004);
    chk("exc_flush2", 32'(IF_Flush), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("exc_addr3", IMEM_Addr, 32'h8000_1004);
    chk("exc_flush3", 32'(IF_Flush), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("exc_addr4", IMEM_Addr, 32'h8000_1004);
    chk("exc_discard", 32'(IF_Stall), 32'd1);
    chk("exc_flush4", 32'(IF_Flush), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("vec_addr", IMEM_Addr, 32'h8000_0180);
    chk("vec_flush", 32'(IF_Flush), 32'd0);

    // Branch-likely cancel of the delay slot
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("cancel_addr", IMEM_Addr, 32'h8000_0184);
    chk("cancel_flush", 32'(IF_Flush), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("cancel_seq_addr", IMEM_Addr, 32'h8000_0188);

    // Reset while a request is waiting
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    RST_N = 1'b0;
    #1;
    chk("async_rst_req", 32'(IMEM_Req), 32'd0);
    chk("async_rst_stall", 32'(IF_Stall), 32'd1);
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("restart_req", 32'(IMEM_Req), 32'd1);
    chk("restart_addr", IMEM_Addr, RV);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r     = $urandom;
      t     = $urandom;
      v     = $urandom;
      isbr  = (r[6:4] == 3'd0);
      taken = isbr & r[7];
      step(r[1:0] != 2'd0, r[3:2] == 2'd0, isbr, taken, t,
           isbr & ~taken & r[8], r[14:9] == 6'd0, v);
    end

    #2;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
